// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction prefetcher with a decode-side FIFO.
//
// Keeps up to MAX_OUTSTANDING instruction-memory requests in flight and queues
// up to DEPTH fetched words for decode. FIFO space is reserved when a request
// is issued, so a returning response can always be written.
//
// Ports
//   clock_i, reset_i       single clock, asynchronous active-high reset
//   redirect_valid_i/pc_i  flush and restart fetch at a new address
//   imem_req_*             request channel (valid/ready, address)
//   imem_rsp_*             in-order response channel (always accepted)
//   dvalid_o/dready_i      stream toward decode
//   instruction_o, inst_pc_o, inst_fault_o  head FIFO entry (zero when empty)
//
// Build option
//   IFETCH_ALIGN_CHECK_EN  when defined, a redirect to a non word-aligned PC
//                          issues no request, queues a single fault entry and
//                          halts; otherwise the low two PC bits are ignored.
module ifetch_prefetch #(
   parameter int unsigned     XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = 'h8000_0000,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            imem_rsp_err_i,
   output logic            dvalid_o,
   input  logic            dready_i,
   output logic [XLEN-1:0] instruction_o,
   output logic [XLEN-1:0] inst_pc_o,
   output logic            inst_fault_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {StFetch, StHalted} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            req_valid_q, req_valid_d;
   logic [OW-1:0]   outstanding_q, outstanding_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic [TW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   // PC tags of in-flight requests, and the instruction FIFO storage
   logic [XLEN-1:0] tag_mem   [MAX_OUTSTANDING];
   logic [XLEN-1:0] data_mem  [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic            fault_mem [DEPTH];

   logic            req_hs, pop;
   logic            wr_en, wr_fault;
   logic [PW-1:0]   wr_idx;
   logic [XLEN-1:0] wr_data, wr_pc;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
   endfunction

   assign imem_req_valid_o = req_valid_q;
   assign imem_req_addr_o  = fetch_pc_q;
   assign dvalid_o         = (count_q != '0);
   assign instruction_o    = dvalid_o ? data_mem[rd_ptr_q]  : '0;
   assign inst_pc_o        = dvalid_o ? pc_mem[rd_ptr_q]    : '0;
   assign inst_fault_o     = dvalid_o ? fault_mem[rd_ptr_q] : 1'b0;

   always_comb begin
      req_hs        = req_valid_q & imem_req_ready_i;
      pop           = dvalid_o & dready_i;
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      drop_d        = drop_q;
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;
      rd_ptr_d      = rd_ptr_q;
      wr_en         = 1'b0;
      wr_idx        = wr_ptr_q;
      wr_data       = imem_rsp_data_i;
      wr_pc         = tag_mem[tag_rd_q];
      wr_fault      = imem_rsp_err_i;
      outstanding_d = outstanding_q + OW'(req_hs) - OW'(imem_rsp_valid_i);

      if (req_hs) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
         tag_wr_d   = tag_inc(tag_wr_q);
      end

      if (imem_rsp_valid_i) begin
         tag_rd_d = tag_inc(tag_rd_q);
         if (drop_q != '0) begin
            drop_d = drop_q - OW'(1);
         end else begin
            wr_en = 1'b1;
            if (imem_rsp_err_i) begin
               wr_data = '0;
               state_d = StHalted;
            end
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d  = count_q + CW'(wr_en) - CW'(pop);

      if (redirect_valid_i) begin
         // Everything still in flight after this cycle's events is stale; a
         // response arriving this cycle is simply not written.
         wr_en      = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         drop_d     = outstanding_d;
         state_d    = StFetch;
         fetch_pc_d = redirect_pc_i & ~XLEN'(3);
`ifdef IFETCH_ALIGN_CHECK_EN
         if (redirect_pc_i[1:0] != 2'b00) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            wr_data    = '0;
            wr_pc      = redirect_pc_i;
            wr_fault   = 1'b1;
            wr_ptr_d   = PW'(1);
            count_d    = CW'(1);
            state_d    = StHalted;
            fetch_pc_d = redirect_pc_i;
         end
`endif
      end

      // Registered request valid, sized against post-update occupancy so a
      // response always finds a free FIFO slot.
      req_valid_d = (state_d == StFetch) &&
                    (32'(outstanding_d) < MAX_OUTSTANDING) &&
                    (32'(outstanding_d) + 32'(count_d) < DEPTH);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StFetch;
         fetch_pc_q    <= RESET_PC;
         req_valid_q   <= 1'b0;
         outstanding_q <= '0;
         drop_q        <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         req_valid_q   <= req_valid_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: outputs are gated by the occupancy count.
   always_ff @(posedge clock_i) begin
      if (req_hs) begin
         tag_mem[tag_wr_q] <= fetch_pc_q;
      end
      if (wr_en) begin
         data_mem[wr_idx]  <= wr_data;
         pc_mem[wr_idx]    <= wr_pc;
         fault_mem[wr_idx] <= wr_fault;
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   logic        dvalid, dready;
   logic [31:0] instruction, inst_pc;
   logic        inst_fault;

   ifetch_prefetch #(
      .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clock_i(clk), .reset_i(rst),
      .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .imem_rsp_err_i(rsp_err),
      .dvalid_o(dvalid), .dready_i(dready),
      .instruction_o(instruction), .inst_pc_o(inst_pc), .inst_fault_o(inst_fault)
   );

   initial forever #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, required 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory contents and fault map ----------------
   bit        err_en = 0;
   logic [5:0] fault_sel = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   function automatic bit is_fault(input logic [31:0] a);
      return err_en && (a[7:2] == fault_sel);
   endfunction

   // ---------------- reference model: expected decode stream ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gen_pc;
   bit          stream_closed;
   bit          seen_fault;
   int          after_fault;
   int          pops = 0;

   function automatic void refill();
      exp_t e;
      while (!stream_closed && exp_q.size() < 8) begin
         e.pc    = gen_pc;
         e.fault = is_fault(gen_pc);
         e.data  = e.fault ? 32'h0 : mem_word(gen_pc);
         exp_q.push_back(e);
         gen_pc += 32'd4;
      end
   endfunction

   // A new stream starts at pc: sequential words until a faulting word.
   function automatic void restart(input logic [31:0] pc);
      exp_t e;
      exp_q.delete();
      seen_fault    = 0;
      after_fault   = 0;
      stream_closed = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) begin
         e.pc = pc; e.data = '0; e.fault = 1'b1;
         exp_q.push_back(e);
         stream_closed = 1;
         return;
      end
`endif
      gen_pc = pc & ~32'd3;
      refill();
   endfunction

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && dvalid && dready) begin
            pops++;
            refill();
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pop: got pc 'h%0h, required no entry", inst_pc);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", inst_pc, e.pc);
               check("pop_data", instruction, e.data);
               check("pop_fault", 32'(inst_fault), 32'(e.fault));
               if (seen_fault) begin
                  after_fault++;
                  check("post_fault_entries", 32'(after_fault <= int'(MAXO) - 1), 32'd1);
               end
               if (e.fault) seen_fault = 1;
            end
         end
      end
   end

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   int          ready_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   int          hs_count = 0;
   logic [31:0] hs_addr[$];
   int          hs_cyc[$];

   initial begin : mem_drive
      pend_t p;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) pend.delete();
         #1;
         rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
         if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = mem_word(p.addr);
            rsp_err   = is_fault(p.addr);
         end
         req_ready = ($urandom_range(99) < ready_pct);
      end
   end

   initial begin : mem_accept
      pend_t p;
      forever begin
         @(negedge clk);
         if (!rst && req_valid && req_ready) begin
            p.addr = req_addr;
            p.due  = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(p);
            hs_count++;
            hs_addr.push_back(req_addr);
            hs_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- driver ----------------
   int          dr_pct = 100;
   bit          redir_now = 0;
   logic [31:0] redir_now_pc = '0;
   bit          redir_pend = 0;
   logic [31:0] redir_pend_pc = '0;

   task automatic step();
      @(posedge clk);
      if (redir_pend) begin
         restart(redir_pend_pc);
         redir_pend = 0;
      end
      #1;
      dready = ($urandom_range(99) < dr_pct);
      redirect_valid = 1'b0;
      if (redir_now && !rst) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_now_pc;
         redir_pend     = 1;
         redir_pend_pc  = redir_now_pc;
      end
      redir_now = 0;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redir_now = 1; redir_now_pc = pc;
      step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      restart(RESET_PC);
      redir_pend = 0;
      repeat (3) step();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_hs(input int target, input int budget, input string name);
      int n = 0;
      while (hs_count < target && n < budget) begin
         step();
         n++;
      end
      if (hs_count < target) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: got %0d requests, required %0d within %0d cycles",
                  name, hs_count, target, budget);
      end
   endtask

   initial begin : driver
      int base, n, p0;
      dready = 1'b0;
      // Reset state
      #1 rst = 1'b1;
      restart(RESET_PC);
      #1;
      check("rst_dvalid", 32'(dvalid), 32'd0);
      check("rst_instruction", instruction, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_fault", 32'(inst_fault), 32'd0);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_req_addr", req_addr, RESET_PC);

      // Back-to-back sequential fetch, 1-cycle memory, decode always ready
      repeat (2) step();
      hs_addr.delete(); hs_cyc.delete();
      base = hs_count;
      @(negedge clk);
      rst = 1'b0;
      step();
      check("first_req_valid", 32'(req_valid), 32'd1);
      check("first_req_addr", req_addr, RESET_PC);
      wait_hs(base + 3, 20, "seq_hs_timeout");
      if (hs_addr.size() >= 3) begin
         check("seq_addr0", hs_addr[0], 32'h8000_0000);
         check("seq_addr1", hs_addr[1], 32'h8000_0004);
         check("seq_addr2", hs_addr[2], 32'h8000_0008);
         check("seq_b2b_01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
         check("seq_b2b_12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd1);
      end
      p0 = pops;
      repeat (12) step();
      check("seq_progress", 32'(pops > p0), 32'd1);

      // Backpressure: FIFO capacity bounds issue
      dr_pct = 0;
      do_reset();
      base = hs_count;
      repeat (20) step();
      check("full_hs_count", 32'(hs_count - base), 32'(DEPTH));
      check("full_req_valid", 32'(req_valid), 32'd0);
      check("full_dvalid", 32'(dvalid), 32'd1);
      dr_pct = 100;
      step();
      dr_pct = 0;
      repeat (10) step();
      check("one_pop_one_req", 32'(hs_count - base), 32'(DEPTH + 1));

      // Redirect with two requests in flight
      dr_pct = 100; lat_min = 4; lat_max = 4;
      do_reset();
      base = hs_count;
      wait_hs(base + 2, 20, "inflight_hs_timeout");
      n = hs_addr.size();
      redirect_to(32'h8000_1000);
      repeat (30) step();
      if (hs_addr.size() > n) check("redir_first_addr", hs_addr[n], 32'h8000_1000);
      else check("redir_any_req", 32'(hs_addr.size()), 32'(n + 1));

      // Access fault halts issue; redirect resumes
      lat_min = 1; lat_max = 1; err_en = 1; fault_sel = 6'd2;
      do_reset();
      repeat (30) step();
      check("fault_seen", 32'(seen_fault), 32'd1);
      check("halt_req_valid", 32'(req_valid), 32'd0);
      base = hs_count;
      repeat (20) step();
      check("halt_no_req", 32'(hs_count - base), 32'd0);
      n = hs_addr.size();
      redirect_to(32'h8000_0000);
      repeat (10) step();
      if (hs_addr.size() > n) check("resume_addr", hs_addr[n], 32'h8000_0000);
      else check("resume_any_req", 32'(hs_addr.size()), 32'(n + 1));

      // Misaligned redirect
      err_en = 0;
      do_reset();
      repeat (10) step();
      redirect_to(32'h8000_0002);
      step();
      n = hs_addr.size();
      p0 = pops;
      repeat (20) step();
`ifdef IFETCH_ALIGN_CHECK_EN
      check("misalign_no_req", 32'(hs_addr.size()), 32'(n));
      check("misalign_one_entry", 32'(pops - p0), 32'd1);
`else
      if (hs_addr.size() > n) check("misalign_addr", hs_addr[n], 32'h8000_0000);
      else check("misalign_any_req", 32'(hs_addr.size()), 32'(n + 1));
`endif

      // Asynchronous reset mid-transfer
      dr_pct = 0; lat_min = 3; lat_max = 3;
      redirect_to(32'h8000_0000);
      repeat (12) step();
      check("pre_reset_dvalid", 32'(dvalid), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      restart(RESET_PC);
      redir_pend = 0;
      #1;
      check("async_rst_dvalid", 32'(dvalid), 32'd0);
      check("async_rst_req_valid", 32'(req_valid), 32'd0);
      check("async_rst_req_addr", req_addr, RESET_PC);
      repeat (2) step();
      @(negedge clk);
      rst = 1'b0;
      step();
      check("restart_req_valid", 32'(req_valid), 32'd1);
      check("restart_req_addr", req_addr, RESET_PC);
      dr_pct = 100;
      repeat (20) step();

      // Randomized traffic
      err_en = 1; fault_sel = 6'($urandom_range(63));
      ready_pct = 70; lat_min = 1; lat_max = 4;
      do_reset();
      p0 = pops;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) dr_pct = int'($urandom_range(100, 20));
         if ($urandom_range(999) < 2) begin
            do_reset();
         end else if ($urandom_range(99) < 3) begin
            redirect_to(32'h8000_0000 | (32'($urandom_range(255)) << 2) |
                        (($urandom_range(99) < 20) ? 32'($urandom_range(3)) : 32'd0));
         end else begin
            step();
         end
      end
      dr_pct = 100;
      repeat (20) step();
      check("random_progress", 32'(pops - p0 > 100), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
